// File: rtl/network_interface.sv
// Mesh network interface: credit-based flit injection toward the router local port
// and a 4-entry first-word-fall-through ejection FIFO that returns credits on pop.
module network_interface #(
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 32,
   parameter int CREDITS = 4,
   parameter int FLIT_W  = 1 + 2*ADDR_W + DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] my_addr_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   input  logic [ADDR_W-1:0] tx_dest_i,
   input  logic [DATA_W-1:0] tx_data_i,
   output logic [FLIT_W-1:0] inject_flit_o,
   input  logic              credit_incr_i,
   input  logic [FLIT_W-1:0] eject_flit_i,
   output logic              rx_valid_o,
   input  logic              rx_ready_i,
   output logic [DATA_W-1:0] rx_data_o,
   output logic [ADDR_W-1:0] rx_src_o,
   output logic              eject_credit_o,
   output logic              credit_err_o,
   output logic              eject_ovf_o,
   output logic              misroute_o,
   output logic [15:0]       stall_cnt_o
);

   localparam int            CW   = $clog2(CREDITS + 1);
   localparam logic [CW-1:0] CMAX = CW'(CREDITS);
   localparam int            EW   = ADDR_W + DATA_W;

   typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, STALL = 2'd2} inj_state_t;

   inj_state_t    state, state_nxt;
   logic [CW-1:0] credit_cnt;
   logic          accept;

   // Gating with rst keeps the core from seeing ready while the block is held in reset.
   assign tx_ready_o = rst & (credit_cnt != '0);
   assign accept     = tx_valid_i & tx_ready_o;

   always_comb begin
      state_nxt = IDLE;
      if (accept)
         state_nxt = SEND;
      else if (tx_valid_i && credit_cnt == '0)
         state_nxt = STALL;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         stall_cnt_o <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt == STALL && stall_cnt_o != 16'hFFFF)
            stall_cnt_o <= stall_cnt_o + 16'd1;
      end
   end

   // A returned credit and an accept in the same cycle cancel out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credit_cnt   <= CMAX;
         credit_err_o <= 1'b0;
      end else if (accept && !credit_incr_i) begin
         credit_cnt <= credit_cnt - CW'(1);
      end else if (!accept && credit_incr_i) begin
         if (credit_cnt == CMAX)
            credit_err_o <= 1'b1;
         else
            credit_cnt <= credit_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         inject_flit_o <= '0;
      else if (accept)
         inject_flit_o <= {1'b1, tx_dest_i, my_addr_i, tx_data_i};
      else
         inject_flit_o <= '0;
   end

   // Ejection side
   logic [EW-1:0]     mem [4];
   logic [1:0]        wr_ptr, rd_ptr;
   logic [2:0]        count;
   logic              ej_vld, full, push, pop;
   logic [ADDR_W-1:0] ej_dest, ej_src;
   logic [DATA_W-1:0] ej_data;

   assign ej_vld  = eject_flit_i[FLIT_W-1];
   assign ej_dest = eject_flit_i[FLIT_W-2 -: ADDR_W];
   assign ej_src  = eject_flit_i[EW-1 -: ADDR_W];
   assign ej_data = eject_flit_i[DATA_W-1:0];

   assign full       = (count == 3'd4);
   assign rx_valid_o = (count != 3'd0);
   assign pop        = rx_valid_o & rx_ready_i;
   // When full, a push is only taken if the head leaves in the same cycle.
   assign push       = ej_vld & (~full | pop);

   assign {rx_src_o, rx_data_o} = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {ej_src, ej_data};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         eject_credit_o <= 1'b0;
         eject_ovf_o    <= 1'b0;
         misroute_o     <= 1'b0;
      end else begin
         eject_credit_o <= pop;
         if (push)
            wr_ptr <= wr_ptr + 2'd1;
         if (pop)
            rd_ptr <= rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
         if (ej_vld && full && !pop)
            eject_ovf_o <= 1'b1;
         if (ej_vld && ej_dest != my_addr_i)
            misroute_o <= 1'b1;
      end
   end

endmodule

// File: doc/network_interface.md
NETWORK_INTERFACE -- requirements
Module: network_interface

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- ADDR_W, 4, node address width ({x[1:0], y[1:0]}).
- DATA_W, 32, payload width.
- CREDITS, 4, router local input-buffer depth; initial injection credit count.
- FLIT_W, 1+2*ADDR_W+DATA_W, flit width; flit = {valid, dest, src, data}, valid at bit FLIT_W-1.

REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock.
- rst, in, 1, asynchronous active-low reset.
- my_addr_i, in, ADDR_W, this node's address; written into the src field.
- tx_valid_i, in, 1, core has a packet to send.
- tx_ready_o, out, 1, NI accepts the packet this cycle.
- tx_dest_i, in, ADDR_W, destination node.
- tx_data_i, in, DATA_W, payload.
- inject_flit_o, out, FLIT_W, flit to the router local input.
- credit_incr_i, in, 1, router freed one local-input slot.
- eject_flit_i, in, FLIT_W, flit from the router local output; valid bit qualifies it.
- rx_valid_o, out, 1, ejection FIFO head is valid.
- rx_ready_i, in, 1, core consumes the head.
- rx_data_o, out, DATA_W, head payload.
- rx_src_o, out, ADDR_W, head source address.
- eject_credit_o, out, 1, one-cycle pulse returning one credit to the router.
- credit_err_o, out, 1, sticky flag: credit overflow.
- eject_ovf_o, out, 1, sticky flag: ejection FIFO overflow.
- misroute_o, out, 1, sticky flag: ejected flit dest != my_addr_i.
- stall_cnt_o, out, 16, saturating count of credit-starved cycles.

Function
REQ-003 SHALL keep credit_cnt (0..CREDITS) and drive tx_ready_o = (credit_cnt != 0) combinationally; tx_ready_o SHALL be 0 while rst is low.
REQ-004 On an accepted transfer (tx_valid_i & tx_ready_o), the block SHALL register inject_flit_o = {1, tx_dest_i, my_addr_i, tx_data_i} for exactly the next cycle; otherwise inject_flit_o SHALL be all zeros.
REQ-005 credit_cnt update rules:
- accept only: decrement by 1.
- credit_incr_i only: increment by 1.
- both in the same cycle: unchanged.
REQ-006 If credit_incr_i arrives with credit_cnt==CREDITS and no accept, credit_cnt SHALL stay at CREDITS and credit_err_o SHALL set.
REQ-007 The injection FSM SHALL have three states:
- IDLE: no transfer this cycle and not starved.
- SEND: transfer accepted this cycle.
- STALL: tx_valid_i=1 and credit_cnt==0.
- Transitions are evaluated every cycle from the current inputs.
- stall_cnt_o SHALL increment once per STALL cycle and saturate at 16'hFFFF.
REQ-008 The ejection FIFO SHALL be 4-entry, first-word-fall-through, and store {src, data}.
- A push occurs when eject_flit_i valid bit is 1.
- rx_valid_o SHALL assert the cycle after a push into an empty FIFO.
REQ-009 A pop SHALL occur when rx_valid_o & rx_ready_i.
- Each pop SHALL produce eject_credit_o=1 in the following cycle only.
REQ-010 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full; no overflow results.
REQ-011 A push into a full FIFO with no pop SHALL be dropped, set eject_ovf_o, and leave FIFO contents unchanged.
REQ-012 An ejected flit with dest != my_addr_i SHALL still be enqueued and SHALL set misroute_o.
REQ-013 FIFO read/write pointers SHALL be 2-bit and wrap 3->0; occupancy SHALL be tracked by a 3-bit count (0..4).

Reset
REQ-014 While rst=0, regardless of clk, the block SHALL hold the following reset values:
- credit_cnt=CREDITS; FSM=IDLE.
- FIFO empty (pointers and count 0).
- inject_flit_o=0, rx_valid_o=0, eject_credit_o=0.
- sticky flags=0, stall_cnt_o=0.
REQ-015 Reset asserted mid-operation SHALL discard in-flight inject and FIFO contents with no credit pulse.
- The first accept is possible in the first cycle after rst deasserts.

Verification
REQ-016 The bench SHALL cover the following scenarios:
- Reset release with tx_valid_i=1, dest=4'h5, data=32'hA5A5_0001, my_addr=4'h3 -> next cycle inject_flit_o={1,5,3,A5A50001}, credit_cnt 4->3.
- Five back-to-back sends with no credit_incr_i -> four flits, then tx_ready_o=0 and STALL; stall_cnt_o increments by 1 per cycle; one credit_incr_i -> fifth flit sent.
- credit_incr_i with a simultaneous accept at credit_cnt=2 -> stays 2; credit_incr_i at credit_cnt=4 -> credit_err_o=1.
- Five ejected valid flits with rx_ready_i=0 -> 4 stored, eject_ovf_o=1; then drain with rx_ready_i=1 -> 4 reads in order, 4 eject_credit_o pulses each one cycle after its pop.
- FIFO full with a simultaneous push and pop -> count stays 4, eject_ovf_o stays 0, order preserved across pointer wrap.
- Ejected flit dest=4'h7 with my_addr=4'h3 -> delivered and misroute_o=1; rst pulse mid-drain -> rx_valid_o=0 immediately, no eject_credit_o.
